// File: rtl/spie_buf_pkg.sv
// Shared definitions for the buffered SPI front-end: register bit positions
// and the transfer sequencer state encoding.
package spie_buf_pkg;

  localparam int ST_IDLE       = 0;
  localparam int ST_TX_FULL    = 1;
  localparam int ST_TX_EMPTY   = 2;
  localparam int ST_RX_FULL    = 3;
  localparam int ST_RX_EMPTY   = 4;
  localparam int ST_TX_OVF     = 5;
  localparam int ST_TX_CNT_LSB = 8;
  localparam int ST_RX_CNT_LSB = 16;

  localparam int CTRL_FLUSH      = 0;
  localparam int CTRL_RX_DISCARD = 1;
  localparam int CTRL_CLR_OVF    = 2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    BUSY  = 2'd2
  } seq_state_t;

endpackage

// File: rtl/spie_buf_if.sv
// IO bus between the CPU and the buffered SPI front-end.
interface spie_buf_if;
  logic        stb;
  logic        we;
  logic        addr;
  logic [31:0] data_in;
  logic [31:0] data_out;
  logic        ack;

  modport master (output stb, output we, output addr, output data_in,
                  input data_out, input ack);
  modport slave  (input stb, input we, input addr, input data_in,
                  output data_out, output ack);
endinterface

// File: rtl/spie_fifo.sv
// Synchronous first-word-fall-through FIFO; push is qualified by full before
// any same-cycle pop, and clr empties it at the edge.
module spie_fifo #(
  parameter int width      = 32,
  parameter int depth_log2 = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clr,
  input  logic                  push,
  input  logic                  pop,
  input  logic [width-1:0]      wdata,
  output logic [width-1:0]      rdata,
  output logic                  full,
  output logic                  empty,
  output logic [depth_log2:0]   count
);

  localparam int depth = 2 ** depth_log2;

  logic [width-1:0]      mem [depth];
  logic [depth_log2-1:0] wr_ptr;
  logic [depth_log2-1:0] rd_ptr;
  logic                  do_push;
  logic                  do_pop;

  assign full    = (count == (depth_log2 + 1)'(depth));
  assign empty   = (count == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign rdata   = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (clr) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + (depth_log2 + 1)'(do_push) - (depth_log2 + 1)'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !clr) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/spie_buf.sv
// Buffered SPI front-end: TX/RX FIFOs between the IO bus and the shift engine,
// plus a sequencer that issues one engine transfer at a time.
//
//   state | meaning
//   IDLE  | waiting for a TX word, a ready engine and RX room
//   START | eng_start pulse, word already latched in eng_data_tx
//   BUSY  | transfer in flight, waiting for eng_rdy
module spie_buf
  import spie_buf_pkg::*;
#(
  parameter int depth_log2 = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  spie_buf_if.slave     bus,
  output logic          eng_start,
  output logic [31:0]   eng_data_tx,
  input  logic [31:0]   eng_data_rx,
  input  logic          eng_rdy
);

  seq_state_t state_q;
  seq_state_t state_d;

  logic wr_data, rd_data, wr_ctrl, rd_ctrl, flush;
  logic tx_pop, rx_push;
  logic tx_ovf, rx_discard, flushed_q;

  logic [31:0]         tx_rdata, rx_rdata;
  logic                tx_full, tx_empty, rx_full, rx_empty;
  logic [depth_log2:0] tx_count, rx_count;
  logic [31:0]         status;

  assign wr_data = bus.stb &  bus.we & ~bus.addr;
  assign rd_data = bus.stb & ~bus.we & ~bus.addr;
  assign wr_ctrl = bus.stb &  bus.we &  bus.addr;
  assign rd_ctrl = bus.stb & ~bus.we &  bus.addr;
  assign flush   = wr_ctrl & bus.data_in[CTRL_FLUSH];
  assign bus.ack = bus.stb;

  spie_fifo #(.width(32), .depth_log2(depth_log2)) u_tx_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (flush),
    .push  (wr_data),
    .pop   (tx_pop),
    .wdata (bus.data_in),
    .rdata (tx_rdata),
    .full  (tx_full),
    .empty (tx_empty),
    .count (tx_count)
  );

  spie_fifo #(.width(32), .depth_log2(depth_log2)) u_rx_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (flush),
    .push  (rx_push),
    .pop   (rd_data),
    .wdata (eng_data_rx),
    .rdata (rx_rdata),
    .full  (rx_full),
    .empty (rx_empty),
    .count (rx_count)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_ovf     <= 1'b0;
      rx_discard <= 1'b0;
    end else begin
      if (flush || (wr_ctrl && bus.data_in[CTRL_CLR_OVF])) tx_ovf <= 1'b0;
      else if (wr_data && tx_full)                          tx_ovf <= 1'b1;
      if (wr_ctrl) rx_discard <= bus.data_in[CTRL_RX_DISCARD];
    end
  end

  // Remembers a flush that landed while a transfer was in flight so its result is dropped.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      eng_data_tx <= '0;
      flushed_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      if (tx_pop) begin
        eng_data_tx <= tx_rdata;
        flushed_q   <= 1'b0;
      end else if (flush && state_q != IDLE) begin
        flushed_q <= 1'b1;
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    tx_pop    = 1'b0;
    rx_push   = 1'b0;
    eng_start = 1'b0;
    case (state_q)
      IDLE: begin
        if (!tx_empty && eng_rdy && (!rx_full || rx_discard) && !flush) begin
          tx_pop  = 1'b1;
          state_d = START;
        end
      end
      START: begin
        eng_start = 1'b1;
        state_d   = BUSY;
      end
      BUSY: begin
        if (eng_rdy) begin
          rx_push = ~rx_discard & ~flushed_q & ~flush;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    status                          = '0;
    status[ST_IDLE]                 = (state_q == IDLE) & tx_empty;
    status[ST_TX_FULL]              = tx_full;
    status[ST_TX_EMPTY]             = tx_empty;
    status[ST_RX_FULL]              = rx_full;
    status[ST_RX_EMPTY]             = rx_empty;
    status[ST_TX_OVF]               = tx_ovf;
    status[ST_TX_CNT_LSB +: 8]      = 8'(tx_count);
    status[ST_RX_CNT_LSB +: 8]      = 8'(rx_count);
  end

  always_comb begin
    bus.data_out = '0;
    if (rd_data && !rx_empty) bus.data_out = rx_rdata;
    else if (rd_ctrl)         bus.data_out = status;
  end

endmodule

// File: tb/tb_spie_buf.sv
// Scoreboard bench for spie_buf (depth 4): expected read data and engine words
// are queued by the stimulus and checked by a monitor on the falling edge.
module tb_spie_buf;

  logic        clk;
  logic        rst_n;
  logic        eng_start;
  logic [31:0] eng_data_tx;
  logic [31:0] eng_data_rx;
  logic        eng_rdy;

  spie_buf_if bus ();

  spie_buf #(.depth_log2(2)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .bus         (bus),
    .eng_start   (eng_start),
    .eng_data_tx (eng_data_tx),
    .eng_data_rx (eng_data_rx),
    .eng_rdy     (eng_rdy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_vec = 0;
  int n_err = 0;

  logic [31:0] exp_rd[$];
  string       exp_rd_name[$];
  logic [31:0] exp_tx[$];
  int          start_log[$];

  // Engine model: 8-cycle transfers echoing the inverted word; eng_hold fakes a busy engine.
  logic        eng_rdy_q;
  logic        eng_hold;
  logic [3:0]  eng_cnt;
  logic [31:0] eng_lat;
  assign eng_rdy = eng_rdy_q & ~eng_hold;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      eng_rdy_q   <= 1'b1;
      eng_cnt     <= '0;
      eng_lat     <= '0;
      eng_data_rx <= '0;
    end else if (eng_start) begin
      eng_rdy_q <= 1'b0;
      eng_cnt   <= 4'd8;
      eng_lat   <= eng_data_tx;
    end else if (!eng_rdy_q) begin
      if (eng_cnt != 0) eng_cnt <= eng_cnt - 4'd1;
      else begin
        eng_rdy_q   <= 1'b1;
        eng_data_rx <= ~eng_lat;
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %08h expected %08h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (bus.stb && !bus.we) begin
      if (exp_rd.size() == 0) check("unexpected_read", bus.data_out, 32'hDEAD_BEEF);
      else check(exp_rd_name.pop_front(), bus.data_out, exp_rd.pop_front());
    end
    if (eng_start) begin
      start_log.push_back(cyc);
      if (exp_tx.size() == 0) check("unexpected_start", eng_data_tx, 32'hDEAD_BEEF);
      else check("eng_data_tx", eng_data_tx, exp_tx.pop_front());
    end
  end

  task automatic bus_cycle(input logic w, input logic a, input logic [31:0] d);
    @(posedge clk);
    #1;
    bus.stb = 1'b1; bus.we = w; bus.addr = a; bus.data_in = d;
    @(posedge clk);
    #1;
    bus.stb = 1'b0; bus.we = 1'b0; bus.addr = 1'b0; bus.data_in = '0;
  endtask

  task automatic wr(input logic a, input logic [31:0] d);
    bus_cycle(1'b1, a, d);
  endtask

  task automatic rd(input logic a, input logic [31:0] exp, input string name);
    exp_rd.push_back(exp);
    exp_rd_name.push_back(name);
    bus_cycle(1'b0, a, 32'h0);
  endtask

  task automatic wait_starts(input int n);
    for (int i = 0; i < 200 && start_log.size() < n; i++) begin
      @(posedge clk);
      #1;
    end
    check("start_count", 32'(start_log.size()), 32'(n));
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  int t_wr;

  initial begin
    rst_n = 1'b0;
    bus.stb = 1'b0; bus.we = 1'b0; bus.addr = 1'b0; bus.data_in = '0;
    eng_hold = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;

    // reset state
    check("rst_eng_start", 32'(eng_start), 32'h0);
    check("rst_eng_data_tx", eng_data_tx, 32'h0);
    rd(1'b1, 32'h0000_0015, "rst_status");
    wait_cycles(5);
    check("rst_no_start", 32'(start_log.size()), 32'h0);

    // three words through an echoing engine
    exp_tx.push_back(32'hA5); exp_tx.push_back(32'h5A); exp_tx.push_back(32'h3C);
    wr(1'b0, 32'hA5);
    t_wr = cyc - 1;
    wr(1'b0, 32'h5A);
    wr(1'b0, 32'h3C);
    wait_starts(3);
    wait_cycles(15);
    if (start_log.size() >= 3) begin
      check("start_latency", 32'(start_log[0] - t_wr), 32'd2);
      check("gap_1", 32'(start_log[1] - start_log[0] >= 2), 32'd1);
      check("gap_2", 32'(start_log[2] - start_log[1] >= 2), 32'd1);
    end
    rd(1'b0, 32'hFFFF_FF5A, "rx_0");
    rd(1'b0, 32'hFFFF_FFA5, "rx_1");
    rd(1'b0, 32'hFFFF_FFC3, "rx_2");
    rd(1'b0, 32'h0, "rx_empty_read");
    rd(1'b1, 32'h0000_0015, "status_after_echo");

    // overflow with engine held busy
    eng_hold = 1'b1;
    exp_tx.push_back(32'h11); exp_tx.push_back(32'h22);
    exp_tx.push_back(32'h33); exp_tx.push_back(32'h44);
    wr(1'b0, 32'h11); wr(1'b0, 32'h22); wr(1'b0, 32'h33);
    wr(1'b0, 32'h44); wr(1'b0, 32'h55);
    rd(1'b1, 32'h0000_0432, "status_ovf");
    wr(1'b1, 32'h4);
    rd(1'b1, 32'h0000_0412, "status_ovf_cleared");
    check("hold_no_start", 32'(start_log.size()), 32'd3);

    // RX backpressure
    eng_hold = 1'b0;
    wait_starts(7);
    wait_cycles(15);
    wr(1'b0, 32'h66);
    wr(1'b0, 32'h77);
    wait_cycles(20);
    check("rx_full_stall", 32'(start_log.size()), 32'd7);
    rd(1'b1, 32'h0004_0208, "status_rx_full");
    exp_tx.push_back(32'h66);
    rd(1'b0, 32'hFFFF_FFEE, "rx_bp_0");
    wait_starts(8);
    wait_cycles(20);
    check("one_more_start", 32'(start_log.size()), 32'd8);
    rd(1'b1, 32'h0004_0108, "status_rx_full_again");
    exp_tx.push_back(32'h77);
    rd(1'b0, 32'hFFFF_FFDD, "rx_bp_1");
    rd(1'b0, 32'hFFFF_FFCC, "rx_bp_2");
    rd(1'b0, 32'hFFFF_FFBB, "rx_bp_3");
    rd(1'b0, 32'hFFFF_FF99, "rx_bp_4");
    wait_starts(9);
    wait_cycles(15);
    rd(1'b0, 32'hFFFF_FF88, "rx_bp_5");
    rd(1'b1, 32'h0000_0015, "status_drained");

    // flush while busy
    exp_tx.push_back(32'h99);
    wr(1'b0, 32'h99);
    wait_starts(10);
    wr(1'b0, 32'hAB);
    wr(1'b1, 32'h1);
    rd(1'b1, 32'h0000_0014, "status_flushed_busy");
    wait_cycles(15);
    rd(1'b1, 32'h0000_0015, "status_after_flush");
    rd(1'b0, 32'h0, "rx_after_flush");
    check("flush_no_start", 32'(start_log.size()), 32'd10);

    // rx_discard
    wr(1'b1, 32'h2);
    exp_tx.push_back(32'hC1); exp_tx.push_back(32'hC2); exp_tx.push_back(32'hC3);
    wr(1'b0, 32'hC1); wr(1'b0, 32'hC2); wr(1'b0, 32'hC3);
    wait_starts(13);
    wait_cycles(15);
    rd(1'b1, 32'h0000_0015, "status_discard");
    wr(1'b1, 32'h0);

    // asynchronous reset mid-transfer
    exp_tx.push_back(32'hD1);
    wr(1'b0, 32'hD1);
    wait_starts(14);
    wr(1'b0, 32'hD2);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    bus.stb = 1'b1; bus.we = 1'b0; bus.addr = 1'b1;
    #1;
    check("async_rst_status", bus.data_out, 32'h0000_0015);
    check("async_rst_eng_start", 32'(eng_start), 32'h0);
    check("async_rst_eng_data_tx", eng_data_tx, 32'h0);
    bus.stb = 1'b0; bus.addr = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    rd(1'b1, 32'h0000_0015, "status_after_rst");
    wait_cycles(20);
    check("rst_no_restart", 32'(start_log.size()), 32'd14);

    wait_cycles(3);
    check("rd_queue_drained", 32'(exp_rd.size()), 32'h0);
    check("tx_queue_drained", 32'(exp_tx.size()), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/spie_buf.md
Name: spie_buf

Overview:
- Buffered front-end for the SPI device.
- Sits between the IO bus and the SPI shift engine, the transfer core driven by start/rdy.
- CPU-written transmit words queue in a TX FIFO; a sequencer issues them to the engine one at a time.
- Each received word queues in an RX FIFO for the CPU to read, so software no longer polls rdy per word.

Parameters:
- depth_log2, 4, log2 of each FIFO depth (1..7; depth = 2**depth_log2)

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- stb  in  1  IO strobe
- we  in  1  write enable
- addr  in  1  0 = data, 1 = control/status
- data_in  in  32  write data
- data_out  out  32  read data (combinational)
- ack  out  1  = stb
- eng_start  out  1  one-cycle transfer start to engine
- eng_data_tx  out  32  word to transmit; stable from eng_start until transfer completes
- eng_data_rx  in  32  received word; valid while eng_rdy=1 after a transfer
- eng_rdy  in  1  engine idle. Contract: eng_rdy is low in the cycle after eng_start and rises when the transfer is done.

Behaviour:
- Clock and reset: one clock, clk. rst_n is asynchronous and active-low.
- Reset values: both FIFOs empty, FSM IDLE, eng_start=0, eng_data_tx=0, rx_discard=0, tx_ovf=0.
- Decode: wr_data=stb&we&~addr, rd_data=stb&~we&~addr, wr_ctrl=stb&we&addr, rd_ctrl=stb&~we&addr.
- TX FIFO push (wr_data):
  - accepted iff tx_count<depth, evaluated before any same-cycle pop; no bypass.
  - when full: word dropped, tx_ovf set (sticky).
- RX FIFO pop (rd_data):
  - data_out = RX head (first-word fall-through).
  - pops at clock edge if not empty.
  - if empty: data_out=0 and no pop.
- Status read (rd_ctrl), data_out:
  - [0] idle (FSM IDLE and TX empty)
  - [1] tx_full
  - [2] tx_empty
  - [3] rx_full
  - [4] rx_empty
  - [5] tx_ovf
  - [15:8] tx_count
  - [23:16] rx_count
  - all other bits 0
- Control write (wr_ctrl):
  - [0] flush: empties both FIFOs and clears tx_ovf at the edge.
  - [1] rx_discard: persistent; received words are not stored.
  - [2] clear tx_ovf.
  - Bits are independent; flush and clear in the same write are legal.
- Otherwise data_out=0. ack=stb, zero wait states.
- FSM IDLE:
  - Start condition: TX not empty, eng_rdy=1, (RX not full or rx_discard), and no flush this cycle.
  - If met: pop TX into eng_data_tx, go START.
- FSM START: eng_start=1 for exactly this cycle, then go BUSY.
- FSM BUSY:
  - Wait for eng_rdy=1.
  - On that cycle: push eng_data_rx into RX unless rx_discard or a flush occurred since START; go IDLE.
- Latency:
  - word written in cycle T reaches eng_start in cycle T+2 (FSM idle, engine ready);
  - eng_rdy high in cycle R → rx_count incremented from R+1.
  - Minimum one IDLE cycle between transfers.
- Backpressure: RX full (no discard) stalls new transfers. Only one transfer is ever in flight, so RX cannot overflow.
- Simultaneous events:
  - CPU RX pop and FSM RX push in the same cycle: both occur, count unchanged.
  - CPU TX push and FSM TX pop in the same cycle: both occur.
- Flush mid-transfer: the in-flight transfer completes on the engine; its result is discarded; FSM returns to IDLE normally.
- Reset mid-transfer: state cleared immediately; engine reset is the engine's own responsibility.
- Pointers wrap modulo depth; counts are depth_log2+1 bits wide.

Decomposition:
- Shared package: status bit positions, control bit positions, FSM state encoding (IDLE, START, BUSY).
- Sub-module spie_fifo: generic synchronous FWFT FIFO (width, depth_log2; push, pop, full, empty, count). Instantiated twice, for TX and RX.

Test Plan:
- Reset, then status read → 0x00000015 (idle, tx_empty, rx_empty); eng_start stays 0.
- Write 0xA5, 0x5A, 0x3C with an engine model of 8-cycle transfers echoing ~tx → three eng_start pulses, each ≥1 IDLE cycle apart; RX reads 0xFFFFFF5A, 0xFFFFFFA5, 0xFFFFFFC3; then RX empty read → 0.
- depth_log2=2 with engine held busy, write 5 words → tx_count=4, tx_ovf=1; control write 0x4 → tx_ovf=0.
- Fill RX to 4 (depth_log2=2) and leave 2 words in TX → no eng_start; one RX read → exactly one further transfer starts.
- Flush written during BUSY → FIFOs empty at next cycle; returning word not stored; rx_count=0.
- rx_discard=1, send 3 words → 3 transfers complete and rx_count stays 0.
- Assert rst_n low during BUSY → FSM IDLE, FIFOs empty, eng_start=0 with no clock edge needed.
